// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB master bridge
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response port plus APB3 completer signals
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait counter with timeout detect
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MAX_V  = CW'(CNT_MAX);
  localparam logic [CW-1:0] LAST_V = CW'(CNT_MAX - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_V)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the increment that brings the count up to the limit.
  assign expired_o = (TIMEOUT_CYCLES != 0) && inc_i && (count_q == LAST_V);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready to APB3 master bridge
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  apb_state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic accept;
  logic timed_out;

  assign accept = cmd_ready_q && bus.cmd_valid;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clr_i     (accept),
    .inc_i     ((state_q == ACCESS) && !bus.PREADY),
    .expired_o (timed_out)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.PREADY || timed_out) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so every port comes straight off a flop.
  always_comb begin
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_wdata;
    end
    if (state_q == ACCESS) begin
      if (bus.PREADY) begin
        rsp_err_d   = bus.PSLVERR;
        rsp_rdata_d = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
      end else if (timed_out) begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed and random transfers against an APB register model
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.master)
  );

  int checks = 0;
  int fails  = 0;

  bit [31:0] slv_mem [256];
  bit [31:0] ref_mem [256];

  int cfg_waits  = 0;
  bit cfg_slverr = 1'b0;
  bit cfg_stuck  = 1'b0;
  int acc_cnt    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completer: inserts cfg_waits wait states, randomises APB inputs whenever they must be ignored
  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (!cfg_stuck && acc_cnt == cfg_waits) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = cfg_slverr;
        bus.PRDATA  = bus.PWRITE ? $urandom : slv_mem[bus.PADDR];
      end else begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA  = $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt     = 0;
      bus.PREADY  = 1'($urandom_range(0, 1));
      bus.PSLVERR = 1'($urandom_range(0, 1));
      bus.PRDATA  = $urandom;
    end
  end

  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
      slv_mem[bus.PADDR] <= bus.PWDATA;
  end

  task automatic check_reset_values(input string tag);
    check({tag, " apb"}, 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}), 64'd0);
    check({tag, " rsp"}, 64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 64'd0);
    check({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input int waits, input bit slverr, input bit stuck, input int stall,
                      input string tag);
    apb_rsp_t exp;
    int lat;
    int exp_lat;
    bit done;
    exp.err   = slverr || stuck;
    exp.rdata = (wr || exp.err) ? 32'd0 : ref_mem[addr];
    exp_lat   = stuck ? 2 + 16 : 3 + waits;
    cfg_waits  = waits;
    cfg_slverr = slverr;
    cfg_stuck  = stuck;

    @(negedge PCLK);
    check({tag, " idle cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.rsp_ready = (stall == 0);
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = $urandom;
    lat = 1;
    check({tag, " setup"}, 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.cmd_ready}),
          64'({1'b1, 1'b0, wr, addr, wdata, 1'b0}));

    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge PCLK);
      #1;
      lat++;
      if (bus.rsp_valid) begin
        done = 1'b1;
      end else begin
        check({tag, " access"}, 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.cmd_ready}),
              64'({1'b1, 1'b1, wr, addr, wdata, 1'b0}));
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rsp"}, 64'({bus.rsp_rdata, bus.rsp_err}), 64'(exp));
    check({tag, " resp apb idle"}, 64'({bus.PSEL, bus.PENABLE, bus.cmd_ready}), 64'd0);

    for (int i = 0; i < stall; i++) begin
      @(posedge PCLK);
      #1;
      check({tag, " stall"}, 64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready}),
            64'({1'b1, exp.rdata, exp.err, 1'b0}));
    end
    bus.rsp_ready = 1'b1;
    @(posedge PCLK);
    #1;
    check({tag, " handshake"}, 64'({bus.rsp_valid, bus.cmd_ready, bus.PSEL}), 64'b010);

    if (wr && !exp.err) ref_mem[addr] = wdata;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge PCLK);
    check_reset_values("reset");
    PRESETn = 1'b1;

    xfer(1'b1, 8'h04, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0, "wr04");
    xfer(1'b0, 8'h04, $urandom, 0, 1'b0, 1'b0, 0, "rd04");
    check("rd04 model", 64'(ref_mem[8'h04]), 64'hDEADBEEF);

    xfer(1'b1, 8'h08, $urandom, 1, 1'b0, 1'b0, 0, "wr08");
    xfer(1'b0, 8'h08, $urandom, 3, 1'b0, 1'b0, 0, "rd08_wait3");

    xfer(1'b0, 8'h10, $urandom, 0, 1'b0, 1'b1, 0, "timeout");
    xfer(1'b0, 8'h04, $urandom, 0, 1'b0, 1'b0, 0, "after_timeout");

    xfer(1'b1, 8'h0C, $urandom, 0, 1'b0, 1'b0, 0, "wr0c");
    xfer(1'b0, 8'h0C, $urandom, 0, 1'b1, 1'b0, 0, "rd0c_slverr");
    xfer(1'b1, 8'h0C, $urandom, 2, 1'b1, 1'b0, 0, "wr0c_slverr");

    xfer(1'b0, 8'h04, $urandom, 1, 1'b0, 1'b0, 5, "stall5");

    // Reset pulse in the middle of a stuck ACCESS phase
    cfg_stuck = 1'b1;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h20;
    bus.cmd_wdata = 32'h12345678;
    bus.rsp_ready = 1'b1;
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("pre_reset access", 64'({bus.PSEL, bus.PENABLE}), 64'b11);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async drop", 64'({bus.PSEL, bus.PENABLE}), 64'b00);
    @(negedge PCLK);
    check_reset_values("mid_reset");
    cfg_stuck = 1'b0;
    PRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge PCLK);
      #1;
      check("post_reset quiet", 64'({bus.rsp_valid, bus.PSEL, bus.cmd_ready}), 64'b001);
    end
    xfer(1'b0, 8'h20, $urandom, 0, 1'b0, 1'b0, 0, "rd20_after_reset");

    for (int n = 0; n < 24; n++) begin
      xfer(1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), 2'b00}, $urandom,
           int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), 1'b0,
           int'($urandom_range(0, 2)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
